// File: rtl/decade_chain_sequencer.sv
// decade_chain_sequencer
// Run/pause/clear sequencer for a chain of NDIG 4-bit digit counters.
// A prescaler makes the count tick; each digit's enable comes from a
// carry/borrow cascade over the digit values read back from the chain.
// Optional feature macro: DCS_ONESHOT_EN (adds the 'oneshot' input, which
// stops the chain at its terminal value instead of wrapping).
//
// Requests (start/stop/clear) are plain levels sampled on every rising edge;
// there is no handshake. When several are high at once, clear beats stop and
// stop beats start, in every state.
module decade_chain_sequencer #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 100_000_000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              mode_type,
    input  logic              mode_updown,
`ifdef DCS_ONESHOT_EN
    input  logic              oneshot,
`endif
    input  logic [4*NDIG-1:0] digits,
    output logic [NDIG-1:0]   dig_en,
    output logic              cnt_type,
    output logic              cnt_updown,
    output logic              cnt_clr,
    output logic              running,
    output logic              wrap,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   pre;
    logic            tick;
    logic            latch_mode;
    logic [NDIG-1:0] term;
    logic [NDIG-1:0] en_next;
    logic            wrap_next;
    logic            oneshot_hit;

    // A tick is only issued when nothing interrupts the run this cycle.
    assign tick = (state == ST_RUN) && (pre == PRE_LAST) && !stop && !clear;

`ifdef DCS_ONESHOT_EN
    assign oneshot_hit = oneshot && wrap_next;
`else
    assign oneshot_hit = 1'b0;
`endif

    // Terminal detection per digit under the latched mode; 10..15 in
    // decimal-up never match 9, so out-of-range digits stay non-terminal.
    always_comb begin
        term = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_updown) begin
                term[i] = (digits[4*i +: 4] == 4'd0);
            end else if (cnt_type) begin
                term[i] = (digits[4*i +: 4] == 4'hF);
            end else begin
                term[i] = (digits[4*i +: 4] == 4'd9);
            end
        end
    end

    // Ripple the tick up the chain: a digit counts only when every lower
    // digit sits at its terminal value. What survives past the top is wrap.
    always_comb begin
        logic carry;
        en_next = '0;
        carry   = tick;
        for (int i = 0; i < NDIG; i++) begin
            en_next[i] = carry;
            carry      = carry & term[i];
        end
        wrap_next = carry;
    end

    // Next-state logic with clear > stop > start priority.
    always_comb begin
        state_next = state;
        latch_mode = 1'b0;
        if (clear) begin
            state_next = ST_CLEAR;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !stop) begin
                        state_next = ST_RUN;
                        latch_mode = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_next = ST_PAUSE;
                    end else if (oneshot_hit) begin
                        state_next = ST_IDLE;
                    end
                end
                ST_PAUSE: begin
                    if (start && !stop) begin
                        state_next = ST_RUN;
                    end
                end
                ST_CLEAR: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Prescaler: advances only in an uninterrupted RUN cycle, holds across
    // PAUSE so a resumed run keeps its phase, and is zeroed by CLEAR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre <= '0;
        end else if (state == ST_CLEAR) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else if ((state == ST_RUN) && !stop && !clear) begin
            pre <= pre + PW'(1);
        end
    end

    // Registered enables and wrap; a oneshot stop suppresses every enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig_en <= '0;
            wrap   <= 1'b0;
        end else begin
            dig_en <= oneshot_hit ? '0 : en_next;
            wrap   <= wrap_next;
        end
    end

    // Count mode is captured only when a run starts from IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_type   <= 1'b0;
            cnt_updown <= 1'b0;
        end else if (latch_mode) begin
            cnt_type   <= mode_type;
            cnt_updown <= mode_updown;
        end
    end

    assign running   = (state == ST_RUN);
    assign cnt_clr   = (state == ST_CLEAR);
    assign state_dbg = state;

endmodule

// File: tb/tb_decade_chain_sequencer.sv
// tb_decade_chain_sequencer
// Directed scenarios plus a randomized run checked against a reference model
// that derives digit enables from whole-number arithmetic on the chain value.
// Optional feature macro: DCS_ONESHOT_EN (enables the oneshot scenario).
module tb_decade_chain_sequencer;

  localparam int NDIG     = 2;
  localparam int PRESCALE = 4;
  localparam int W        = NDIG + 5;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_CLEAR = 3;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              stop;
  logic              clear;
  logic              mode_type;
  logic              mode_updown;
  logic              oneshot;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dig_en;
  logic              cnt_type;
  logic              cnt_updown;
  logic              cnt_clr;
  logic              running;
  logic              wrap;
  logic [1:0]        state_dbg;

  int checks = 0;
  int errors = 0;

  // reference model state
  int              m_st;
  int              m_pre;
  logic            m_type;
  logic            m_ud;
  logic [NDIG-1:0] m_en;
  logic            m_wrap;
  logic            m_tickd;

  logic [W-1:0] exp_q[$];

  decade_chain_sequencer #(
    .NDIG(NDIG),
    .PRESCALE(PRESCALE)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .stop(stop),
    .clear(clear),
    .mode_type(mode_type),
    .mode_updown(mode_updown),
`ifdef DCS_ONESHOT_EN
    .oneshot(oneshot),
`endif
    .digits(digits),
    .dig_en(dig_en),
    .cnt_type(cnt_type),
    .cnt_updown(cnt_updown),
    .cnt_clr(cnt_clr),
    .running(running),
    .wrap(wrap),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advancing the chain by one count: which digits change, and does the
  // whole number roll over. Digits are read as a base-10 or base-16 number.
  function automatic logic [NDIG:0] ref_advance(input logic [4*NDIG-1:0] d,
                                                input logic hex, input logic down);
    longint base;
    longint v;
    longint nv;
    longint maxv;
    longint a;
    longint b;
    logic [NDIG:0] r;
    base = hex ? 16 : 10;
    v    = 0;
    maxv = 1;
    for (int i = NDIG - 1; i >= 0; i--) v = v * base + longint'(d[4*i +: 4]);
    for (int i = 0; i < NDIG; i++) maxv = maxv * base;
    nv = down ? (v + maxv - 1) % maxv : (v + 1) % maxv;
    a  = v;
    b  = nv;
    r  = '0;
    for (int i = 0; i < NDIG; i++) begin
      r[i] = ((a % base) != (b % base));
      a = a / base;
      b = b / base;
    end
    r[NDIG] = down ? (v == 0) : (v == maxv - 1);
    return r;
  endfunction

  task automatic model_reset();
    m_st    = M_IDLE;
    m_pre   = 0;
    m_type  = 1'b0;
    m_ud    = 1'b0;
    m_en    = '0;
    m_wrap  = 1'b0;
    m_tickd = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Drive requests for one cycle, update the model, then sample 2ns after
  // the rising edge.
  task automatic step(input logic s, input logic p, input logic c);
    bit tick;
    logic [NDIG:0] adv;
    logic full;
    start = s;
    stop  = p;
    clear = c;
    tick  = (m_st == M_RUN) && (m_pre == PRESCALE - 1) && !p && !c;
    adv   = ref_advance(digits, m_type, m_ud);
    full  = tick && adv[NDIG];
    m_en    = tick ? adv[NDIG-1:0] : '0;
    m_wrap  = full;
    m_tickd = tick;
    if (oneshot && full) m_en = '0;
    if (m_st == M_CLEAR || tick) m_pre = 0;
    else if (m_st == M_RUN && !p && !c) m_pre = m_pre + 1;
    if (c) m_st = M_CLEAR;
    else begin
      case (m_st)
        M_IDLE:  if (s && !p) begin m_st = M_RUN; m_type = mode_type; m_ud = mode_updown; end
        M_RUN:   if (p) m_st = M_PAUSE; else if (oneshot && full) m_st = M_IDLE;
        M_PAUSE: if (s && !p) m_st = M_RUN;
        default: m_st = M_IDLE;
      endcase
    end
    @(posedge clk);
    #2;
  endtask

  task automatic run_to_tick(output bit found);
    found = 1'b0;
    for (int k = 0; k < PRESCALE + 2; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (m_tickd) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    start = 0; stop = 0; clear = 0; mode_type = 0; mode_updown = 0; digits = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    checks++; if (dig_en !== '0) begin errors++; $display("FAIL reset_dig_en: got %b want 0", dig_en); end
    checks++; if (cnt_type !== 1'b0) begin errors++; $display("FAIL reset_cnt_type: got %b want 0", cnt_type); end
    checks++; if (cnt_updown !== 1'b0) begin errors++; $display("FAIL reset_cnt_updown: got %b want 0", cnt_updown); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL reset_cnt_clr: got %b want 0", cnt_clr); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    reset_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic test_up_decimal();
    logic [NDIG-1:0] exp;
    mode_type = 1'b0; mode_updown = 1'b0; digits = 8'h00;
    step(1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running: got %b want 1", running); end
    for (int j = 1; j <= 12; j++) begin
      step(1'b0, 1'b0, 1'b0);
      exp = ((j % PRESCALE) == 0) ? 2'b01 : 2'b00;
      checks++;
      if (dig_en !== exp) begin errors++; $display("FAIL tick_spacing[%0d]: got %b want %b", j, dig_en, exp); end
    end
  endtask

  task automatic test_cascade_decimal();
    bit found;
    digits = 8'h09;
    run_to_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL cascade09_timeout: got no tick want tick"); end
    checks++; if (dig_en !== 2'b11) begin errors++; $display("FAIL cascade09_en: got %b want 11", dig_en); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL cascade09_wrap: got %b want 0", wrap); end
    digits = 8'h99;
    run_to_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL cascade99_timeout: got no tick want tick"); end
    checks++; if (dig_en !== 2'b11) begin errors++; $display("FAIL cascade99_en: got %b want 11", dig_en); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL cascade99_wrap: got %b want 1", wrap); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle: got %b want 0", wrap); end
    checks++; if (dig_en !== 2'b00) begin errors++; $display("FAIL en_one_cycle: got %b want 00", dig_en); end
  endtask

  task automatic test_out_of_range();
    bit found;
    digits = 8'h9A;
    run_to_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL oor_low_timeout: got no tick want tick"); end
    checks++; if (dig_en !== 2'b01) begin errors++; $display("FAIL oor_low_en: got %b want 01", dig_en); end
    digits = 8'hA9;
    run_to_tick(found);
    checks++; if (dig_en !== 2'b11) begin errors++; $display("FAIL oor_high_en: got %b want 11", dig_en); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL oor_high_wrap: got %b want 0", wrap); end
  endtask

  task automatic test_pause();
    digits = 8'h00;
    for (int k = 0; k < PRESCALE + 1; k++) begin
      if (m_pre == PRESCALE - 1) break;
      step(1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++; if (dig_en !== 2'b00) begin errors++; $display("FAIL stop_no_en: got %b want 00", dig_en); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", running); end
    mode_type = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    checks++; if (cnt_type !== 1'b0) begin errors++; $display("FAIL pause_mode_hold: got %b want 0", cnt_type); end
    checks++; if (dig_en !== 2'b00) begin errors++; $display("FAIL pause_no_en: got %b want 00", dig_en); end
    step(1'b1, 1'b0, 1'b0);
    mode_type = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running: got %b want 1", running); end
    checks++; if (dig_en !== 2'b00) begin errors++; $display("FAIL resume_early_en: got %b want 00", dig_en); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (dig_en !== 2'b01) begin errors++; $display("FAIL resume_en: got %b want 01", dig_en); end
  endtask

  task automatic test_clear();
    logic [NDIG-1:0] exp;
    step(1'b1, 1'b0, 1'b1);
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL clear_pulse: got %b want 1", cnt_clr); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_running: got %b want 0", running); end
    step(1'b0, 1'b0, 1'b0);
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clear_single: got %b want 0", cnt_clr); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_idle: got %b want 0", running); end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    checks++; if (cnt_clr !== 1'b1) begin errors++; $display("FAIL clear_held: got %b want 1", cnt_clr); end
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL restart_running: got %b want 1", running); end
    for (int j = 1; j <= PRESCALE; j++) begin
      step(1'b0, 1'b0, 1'b0);
      exp = (j == PRESCALE) ? 2'b01 : 2'b00;
      checks++;
      if (dig_en !== exp) begin errors++; $display("FAIL clear_pre_zero[%0d]: got %b want %b", j, dig_en, exp); end
    end
  endtask

  task automatic test_hex_down();
    bit found;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    mode_type = 1'b1; mode_updown = 1'b1; digits = 8'hF0;
    step(1'b1, 1'b0, 1'b0);
    checks++; if (cnt_type !== 1'b1) begin errors++; $display("FAIL hex_latch_type: got %b want 1", cnt_type); end
    checks++; if (cnt_updown !== 1'b1) begin errors++; $display("FAIL hex_latch_dir: got %b want 1", cnt_updown); end
    run_to_tick(found);
    checks++; if (dig_en !== 2'b11) begin errors++; $display("FAIL hexF0_en: got %b want 11", dig_en); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL hexF0_wrap: got %b want 0", wrap); end
    digits = 8'h00;
    run_to_tick(found);
    checks++; if (dig_en !== 2'b11) begin errors++; $display("FAIL hex00_en: got %b want 11", dig_en); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL hex00_wrap: got %b want 1", wrap); end
  endtask

  task automatic test_random();
    logic [W-1:0] exp;
    logic [W-1:0] got;
    logic s;
    logic p;
    logic c;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NDIG; i++) begin
        if ($urandom_range(0, 1) == 1) digits[4*i +: 4] = m_ud ? 4'd0 : (m_type ? 4'hF : 4'd9);
        else digits[4*i +: 4] = 4'($urandom_range(0, m_type ? 15 : 9));
      end
      mode_type   = 1'($urandom_range(0, 1));
      mode_updown = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 99) < 3);
      p = ($urandom_range(0, 99) < 8);
      s = ($urandom_range(0, 99) < 20);
      step(s, p, c);
      exp_q.push_back({m_wrap, m_en, (m_st == M_RUN), (m_st == M_CLEAR), m_type, m_ud});
      got = {wrap, dig_en, running, cnt_clr, cnt_type, cnt_updown};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %b want %b (wrap,dig_en,running,cnt_clr,type,dir)", n, got, exp);
      end
    end
  endtask

`ifdef DCS_ONESHOT_EN
  task automatic test_oneshot();
    bit found;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    mode_type = 1'b0; mode_updown = 1'b0; digits = 8'h99; oneshot = 1'b1;
    step(1'b1, 1'b0, 1'b0);
    run_to_tick(found);
    checks++; if (!found) begin errors++; $display("FAIL oneshot_timeout: got no tick want tick"); end
    checks++; if (dig_en !== 2'b00) begin errors++; $display("FAIL oneshot_en: got %b want 00", dig_en); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL oneshot_wrap: got %b want 1", wrap); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL oneshot_idle: got %b want 0", running); end
    oneshot = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL oneshot_wrap_once: got %b want 0", wrap); end
  endtask
`endif

  task automatic test_async_reset();
    bit found;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    mode_type = 1'b1; mode_updown = 1'b1; digits = 8'h00;
    step(1'b1, 1'b0, 1'b0);
    run_to_tick(found);
    checks++; if (dig_en !== 2'b11) begin errors++; $display("FAIL prereset_en: got %b want 11", dig_en); end
    reset_n = 1'b0;
    #1;
    checks++; if (dig_en !== '0) begin errors++; $display("FAIL areset_dig_en: got %b want 0", dig_en); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap: got %b want 0", wrap); end
    checks++; if (cnt_type !== 1'b0) begin errors++; $display("FAIL areset_type: got %b want 0", cnt_type); end
    checks++; if (cnt_updown !== 1'b0) begin errors++; $display("FAIL areset_dir: got %b want 0", cnt_updown); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL areset_running: got %b want 0", running); end
    checks++; if (cnt_clr !== 1'b0) begin errors++; $display("FAIL areset_clr: got %b want 0", cnt_clr); end
    model_reset();
    #4;
    reset_n = 1'b1;
    start = 0; stop = 0; clear = 0;
    @(posedge clk);
    #2;
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got %b want 0", running); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    oneshot = 1'b0;
    test_reset();
    test_up_decimal();
    test_cascade_decimal();
    test_out_of_range();
    test_pause();
    test_clear();
    test_hex_down();
    test_random();
`ifdef DCS_ONESHOT_EN
    test_oneshot();
`endif
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
